fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, buffer
// entry layout, NOP word and default reset vector.
package fetch_unit_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of fetched {inst, pc}; slot0 is always the head.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slot0_q, slot1_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else if (push_i && !pop_i) begin
      count_q <= count_q + 2'd1;
    end else if (pop_i && !push_i) begin
      count_q <= count_q - 2'd1;
    end
  end

  // Entries carry no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (pop_i) begin
        slot0_q <= (push_i && count_q == 2'd1) ? push_entry_i : slot1_q;
        if (push_i) slot1_q <= push_entry_i;
      end else if (push_i) begin
        if (count_q == 2'd0) slot0_q <= push_entry_i;
        else                 slot1_q <= push_entry_i;
      end
    end
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry buffer, with redirect handling and a DROP state for abandoned requests.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Rdata,
  output logic        IF_Valid,
  output logic [31:0] IF_Inst,
  output logic [31:0] IF_PC_Plus4
);

  fetch_state_e state_q;
  logic [31:0]  fa_q;
  logic [31:0]  drop_addr_q;
  logic         active_q;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         ack_acc, push, pop;

  // active_q keeps the request low for the first cycle after reset release,
  // so a stray Ack left over from before reset can never be accepted.
  assign Imem_Req   = active_q && (state_q == ST_DROP || count != 2'd2);
  assign Imem_Addr  = (state_q == ST_DROP) ? drop_addr_q : fa_q;
  assign ack_acc    = Imem_Ack && Imem_Req;
  assign push       = (state_q == ST_RUN) && ack_acc && !Redirect;
  assign pop        = PCWrite && IF_Valid && !Redirect;
  assign push_entry = '{inst: Imem_Rdata, pc: fa_q};

  fetch_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (Redirect),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count)
  );

  assign IF_Valid    = (count != 2'd0);
  assign IF_Inst     = IF_Valid ? head.inst : NOP_WORD;
  assign IF_PC_Plus4 = IF_Valid ? head.pc + 32'd4 : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      fa_q     <= RESET_PC;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        ST_RUN: begin
          if (Redirect) begin
            fa_q <= word_align(Redirect_PC);
            if (Imem_Req && !Imem_Ack) state_q <= ST_DROP;
          end else if (push) begin
            fa_q <= fa_q + 32'd4;
          end
        end
        ST_DROP: begin
          if (Redirect) fa_q <= word_align(Redirect_PC);
          if (Imem_Ack) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // The abandoned address must stay on the bus until memory answers it.
  always_ff @(posedge clk) begin
    if (state_q == ST_RUN && Redirect && Imem_Req && !Imem_Ack) drop_addr_q <= fa_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, PCWrite, Redirect, Imem_Ack;
  logic [31:0] Redirect_PC, Imem_Rdata;
  logic        Imem_Req, IF_Valid;
  logic [31:0] Imem_Addr, IF_Inst, IF_PC_Plus4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Ack    (Imem_Ack),
    .Imem_Rdata  (Imem_Rdata),
    .IF_Valid    (IF_Valid),
    .IF_Inst     (IF_Inst),
    .IF_PC_Plus4 (IF_PC_Plus4)
  );

  // Behavioural model: ordered queue of fetched words, fetch address,
  // and whether a discarded request is still owed a reply.
  logic [31:0] m_inst[$];
  logic [31:0] m_pc[$];
  logic [31:0] m_fa, m_daddr;
  bit          m_drop, m_active;

  function automatic bit m_req();
    return m_active && (m_drop || m_inst.size() < 2);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drop ? m_daddr : m_fa;
  endfunction

  task automatic model_reset();
    m_inst.delete();
    m_pc.delete();
    m_fa     = RPC;
    m_daddr  = RPC;
    m_drop   = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic model_step();
    bit          req, ack;
    logic [31:0] addr;
    req  = m_req();
    addr = m_addr();
    ack  = Imem_Ack && req;
    if (Redirect) begin
      if (m_drop) begin
        if (ack) m_drop = 1'b0;
      end else if (req && !ack) begin
        m_drop  = 1'b1;
        m_daddr = addr;
      end
      m_inst.delete();
      m_pc.delete();
      m_fa = {Redirect_PC[31:2], 2'b00};
    end else begin
      if (PCWrite && m_inst.size() > 0) begin
        void'(m_inst.pop_front());
        void'(m_pc.pop_front());
      end
      if (ack) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          m_inst.push_back(Imem_Rdata);
          m_pc.push_back(m_fa);
          m_fa = m_fa + 32'd4;
        end
      end
    end
    m_active = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; PCWrite = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0;
    Imem_Ack = 1'b0; Imem_Rdata = 32'h0;
    model_reset();
    repeat (2) tick();
    n_tests++; if (Imem_Req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", Imem_Req); end
    n_tests++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", IF_Valid); end
    n_tests++; if (IF_Inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h want 0", IF_PC_Plus4); end
    reset = 1'b1;
    tick();
    n_tests++; if (Imem_Req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", Imem_Req); end
    n_tests++; if (Imem_Addr !== RPC) begin n_fail++; $display("FAIL first_addr: got %h want %h", Imem_Addr, RPC); end
  endtask

  task automatic test_stream();
    PCWrite = 1'b1; Imem_Ack = 1'b1;
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: got %b want 1", IF_Valid); end
    n_tests++; if (IF_Inst !== 32'h0040_0000) begin n_fail++; $display("FAIL stream_inst0: got %h want 00400000", IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL stream_pc4_0: got %h want 00400004", IF_PC_Plus4); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Inst !== 32'h0040_0004) begin n_fail++; $display("FAIL stream_inst1: got %h want 00400004", IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0040_0008) begin n_fail++; $display("FAIL stream_pc4_1: got %h want 00400008", IF_PC_Plus4); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Inst !== 32'h0040_0008) begin n_fail++; $display("FAIL stream_inst2: got %h want 00400008", IF_Inst); end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Imem_Rdata = Imem_Addr; tick();
      n_tests++; if (IF_Inst !== 32'h0040_0008) begin n_fail++; $display("FAIL stall_hold%0d: got %h want 00400008", i, IF_Inst); end
      n_tests++; if (Imem_Req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %b want 0", i, Imem_Req); end
    end
    PCWrite = 1'b1;
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Inst !== 32'h0040_000C) begin n_fail++; $display("FAIL unstall_inst1: got %h want 0040000c", IF_Inst); end
    n_tests++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0040_0010) begin n_fail++; $display("FAIL unstall_req: got %b/%h want 1/00400010", Imem_Req, Imem_Addr); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Inst !== 32'h0040_0010) begin n_fail++; $display("FAIL unstall_inst2: got %h want 00400010", IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0040_0014) begin n_fail++; $display("FAIL unstall_pc4: got %h want 00400014", IF_PC_Plus4); end
  endtask

  task automatic test_redirect_outstanding();
    Imem_Ack = 1'b0; Redirect = 1'b1; Redirect_PC = 32'h0040_0100;
    tick();
    Redirect = 1'b0;
    n_tests++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid0: got %b want 0", IF_Valid); end
    n_tests++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0040_0014) begin n_fail++; $display("FAIL drop_hold0: got %b/%h want 1/00400014", Imem_Req, Imem_Addr); end
    tick();
    n_tests++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0040_0014) begin n_fail++; $display("FAIL drop_hold1: got %b/%h want 1/00400014", Imem_Req, Imem_Addr); end
    Imem_Ack = 1'b1; Imem_Rdata = 32'hDEAD_BEEF;
    tick();
    n_tests++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got valid %b want 0", IF_Valid); end
    n_tests++; if (Imem_Addr !== 32'h0040_0100) begin n_fail++; $display("FAIL drop_newaddr: got %h want 00400100", Imem_Addr); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Valid !== 1'b1 || IF_Inst !== 32'h0040_0100) begin n_fail++; $display("FAIL drop_target: got %b/%h want 1/00400100", IF_Valid, IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0040_0104) begin n_fail++; $display("FAIL drop_pc4: got %h want 00400104", IF_PC_Plus4); end
  endtask

  task automatic test_redirect_ack();
    Redirect = 1'b1; Redirect_PC = 32'h0040_0100; Imem_Ack = 1'b1; Imem_Rdata = 32'hBAD0_0001;
    tick();
    Redirect = 1'b0;
    n_tests++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL rdack_valid: got %b want 0", IF_Valid); end
    n_tests++; if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0040_0100) begin n_fail++; $display("FAIL rdack_addr: got %b/%h want 1/00400100", Imem_Req, Imem_Addr); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Inst !== 32'h0040_0100) begin n_fail++; $display("FAIL rdack_inst: got %h want 00400100", IF_Inst); end
  endtask

  task automatic test_misaligned();
    Redirect = 1'b1; Redirect_PC = 32'h0040_0102; Imem_Ack = 1'b1; Imem_Rdata = 32'hBAD0_0002;
    tick();
    Redirect = 1'b0;
    n_tests++; if (Imem_Addr !== 32'h0040_0100) begin n_fail++; $display("FAIL align_addr: got %h want 00400100", Imem_Addr); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Valid !== 1'b1 || IF_Inst !== 32'h0040_0100) begin n_fail++; $display("FAIL align_inst: got %b/%h want 1/00400100", IF_Valid, IF_Inst); end
    n_tests++; if (IF_PC_Plus4 !== 32'h0040_0104) begin n_fail++; $display("FAIL align_pc4: got %h want 00400104", IF_PC_Plus4); end
  endtask

  task automatic test_reset_mid();
    Imem_Ack = 1'b0; PCWrite = 1'b0;
    tick();
    n_tests++; if (Imem_Req !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got req %b want 1", Imem_Req); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if (Imem_Req !== 1'b0 || IF_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got req %b valid %b want 0 0", Imem_Req, IF_Valid); end
    tick();
    Imem_Ack = 1'b1; Imem_Rdata = 32'hBADB_AD00; reset = 1'b1;
    tick();
    n_tests++; if (Imem_Req !== 1'b1 || Imem_Addr !== RPC) begin n_fail++; $display("FAIL rmid_req: got %b/%h want 1/%h", Imem_Req, Imem_Addr, RPC); end
    n_tests++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stray: got valid %b want 0", IF_Valid); end
    Imem_Rdata = Imem_Addr; tick();
    n_tests++; if (IF_Valid !== 1'b1 || IF_Inst !== RPC) begin n_fail++; $display("FAIL rmid_inst: got %b/%h want 1/%h", IF_Valid, IF_Inst, RPC); end
    n_tests++; if (IF_PC_Plus4 !== RPC + 32'd4) begin n_fail++; $display("FAIL rmid_pc4: got %h want %h", IF_PC_Plus4, RPC + 32'd4); end
  endtask

  task automatic test_random();
    bit          prev_req, prev_ack, prev_rst;
    logic [31:0] prev_addr;
    logic [31:0] exp_inst, exp_pc4;
    prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b0; prev_addr = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      exp_inst = (m_inst.size() > 0) ? m_inst[0] : 32'h0;
      exp_pc4  = (m_pc.size() > 0) ? m_pc[0] + 32'd4 : 32'h0;
      n_tests++; if (Imem_Req !== m_req()) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, Imem_Req, m_req()); end
      n_tests++; if (m_req() && Imem_Addr !== m_addr()) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, Imem_Addr, m_addr()); end
      n_tests++; if (IF_Valid !== (m_inst.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %0d", cyc, IF_Valid, m_inst.size()); end
      n_tests++; if (IF_Inst !== exp_inst) begin n_fail++; $display("FAIL rnd_inst c%0d: got %h want %h", cyc, IF_Inst, exp_inst); end
      n_tests++; if (IF_PC_Plus4 !== exp_pc4) begin n_fail++; $display("FAIL rnd_pc4 c%0d: got %h want %h", cyc, IF_PC_Plus4, exp_pc4); end
      if (prev_req && !prev_ack && prev_rst && reset) begin
        n_tests++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_stable c%0d: got %b/%h want 1/%h", cyc, Imem_Req, Imem_Addr, prev_addr);
        end
      end
      if (!reset) reset = 1'b1;
      else if ($urandom % 64 == 0) begin
        reset = 1'b0;
        model_reset();
      end
      PCWrite     = ($urandom % 4) != 0;
      Redirect    = ($urandom % 12) == 0;
      Redirect_PC = 32'h0040_0000 | ($urandom & 32'h0000_0FFF);
      Imem_Ack    = ($urandom % 3) != 0;
      Imem_Rdata  = $urandom;
      prev_req  = Imem_Req;
      prev_addr = Imem_Addr;
      prev_ack  = Imem_Ack;
      prev_rst  = reset;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_ack();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
